// File: rtl/cc_miss_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cc_miss_request_ctrl
//  Description : Cache-line refill sequencer. Accepts one miss at a time from
//                the hit/miss pipeline, pushes the miss address into the Miss
//                Addr FIFO and issues one 8-beat critical-word-first AXI WRAP
//                read burst per miss. Counts bursts in flight by watching
//                R-channel last beats and throttles new misses at
//                MAX_OUTSTANDING.
//  Options     : CC_MISS_STAT_EN - adds miss_cnt_o / stall_cnt_o statistics
//                counters and ports. Undefined by default.
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_miss_request_ctrl #(
    parameter int MAX_OUTSTANDING = 4     // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,

    // Miss request from the hit/miss pipeline
    input  logic        miss_req_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ack_o,

    // AXI AR channel
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,

    // AXI R channel, observed only
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,

    // Miss Addr FIFO push side
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,

    // Status
    output logic [3:0]  outstanding_o,
    output logic        busy_o
`ifdef CC_MISS_STAT_EN
    ,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_max_out   = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] c_arlen     = 4'd7;     // 8 beats per line
    localparam logic [2:0] c_arsize    = 3'd3;     // 8 bytes per beat
    localparam logic [1:0] c_arburst   = 2'b10;    // WRAP

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_AR   = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [3:0]  r_outstanding;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic w_limit_ok;
    logic w_accept;
    logic w_rlast_beat;
    logic w_ar_hs;

    // The limit compare uses the registered count; a last beat arriving in the
    // same cycle frees a slot only from the next cycle on.
    assign w_limit_ok   = (r_outstanding < c_max_out);

    // Gating with rst_n keeps ack/push low while reset is asserted, even
    // though the state register only clears on the next edge.
    assign w_accept     = rst_n
                        & (r_state == S_IDLE)
                        & miss_req_i
                        & ~miss_addr_fifo_full_i
                        & w_limit_ok;

    assign w_rlast_beat = mem_rvalid_i & mem_rready_i & mem_rlast_i;
    assign w_ar_hs      = r_arvalid & mem_arready_i;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign miss_ack_o             = w_accept;
    assign miss_addr_fifo_wren_o  = w_accept;
    // The fill unit needs the full byte address to locate the critical word.
    assign miss_addr_fifo_wdata_o = miss_addr_i;

    assign mem_arvalid_o          = r_arvalid;
    assign mem_araddr_o           = r_araddr;
    assign mem_arlen_o            = c_arlen;
    assign mem_arsize_o           = c_arsize;
    assign mem_arburst_o          = c_arburst;

    assign outstanding_o          = r_outstanding;
    assign busy_o                 = (r_state != S_IDLE) | (r_outstanding != 4'd0);

    // ------------------------------------------------------------------------
    // AR sequencing FSM: capture the beat-aligned address on accept, hold
    // arvalid and araddr until the slave takes the request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Beat-aligned start gives critical-word-first in WRAP mode
                        r_araddr  <= {miss_addr_i[31:3], 3'b000};
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bursts-in-flight counter: +1 per accept, -1 per last R beat. A last
    // beat seen with nothing in flight is ignored rather than wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= 4'd0;
        end else begin
            if (w_accept && !w_rlast_beat) begin
                r_outstanding <= r_outstanding + 4'd1;
            end else if (!w_accept && w_rlast_beat && (r_outstanding != 4'd0)) begin
                r_outstanding <= r_outstanding - 4'd1;
            end
        end
    end

`ifdef CC_MISS_STAT_EN
    // ------------------------------------------------------------------------
    // Statistics: accepted misses and idle-state cycles where a request was
    // presented but blocked (FIFO full or limit reached). Both wrap freely.
    // ------------------------------------------------------------------------
    logic [31:0] r_miss_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall     = (r_state == S_IDLE) & miss_req_i & ~w_accept;
    assign miss_cnt_o  = r_miss_cnt;
    assign stall_cnt_o = r_stall_cnt;

    // Statistics counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_miss_cnt  <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_accept) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cc_miss_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_miss_request_ctrl
//  Description : Self-checking bench for cc_miss_request_ctrl. Directed refill
//                scenarios followed by randomized traffic, all compared each
//                cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_miss_request_ctrl;

    localparam int MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        miss_ack;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic        fifo_full;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  outstanding;
    logic        busy;
`ifdef CC_MISS_STAT_EN
    logic [31:0] miss_cnt;
    logic [31:0] stall_cnt;
`endif

    cc_miss_request_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_i             (miss_req),
        .miss_addr_i            (miss_addr),
        .miss_ack_o             (miss_ack),
        .mem_arvalid_o          (arvalid),
        .mem_arready_i          (arready),
        .mem_araddr_o           (araddr),
        .mem_arlen_o            (arlen),
        .mem_arsize_o           (arsize),
        .mem_arburst_o          (arburst),
        .mem_rvalid_i           (rvalid),
        .mem_rready_i           (rready),
        .mem_rlast_i            (rlast),
        .miss_addr_fifo_full_i  (fifo_full),
        .miss_addr_fifo_wren_o  (wren),
        .miss_addr_fifo_wdata_o (wdata),
        .outstanding_o          (outstanding),
        .busy_o                 (busy)
`ifdef CC_MISS_STAT_EN
        ,
        .miss_cnt_o             (miss_cnt),
        .stall_cnt_o            (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: AR requests not yet taken by the slave sit in a queue
    // (at most one, since a new miss needs an empty queue); bursts in flight
    // are a plain integer.
    // ------------------------------------------------------------------------
    logic [31:0] m_arq[$];
    int          m_out;
    logic [31:0] m_araddr;
    logic [31:0] m_miss;
    logic [31:0] m_stall;
    logic        m_last_acc;

    int n_checks;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_arq.delete();
        m_out      = 0;
        m_araddr   = 32'd0;
        m_miss     = 32'd0;
        m_stall    = 32'd0;
        m_last_acc = 1'b0;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model on the
    // edge using the same inputs the DUT sampled.
    task automatic cycle();
        logic e_acc;
        logic dec;
        @(negedge clk);
        e_acc = rst_n && miss_req && !fifo_full && (m_arq.size() == 0) && (m_out < MAX);
        dec   = rvalid && rready && rlast;
        chk("ack",         32'(miss_ack), 32'(e_acc));
        chk("wren",        32'(wren),     32'(e_acc));
        if (e_acc) chk("wdata", wdata, miss_addr);
        chk("arvalid",     32'(arvalid),  32'(m_arq.size() != 0));
        chk("araddr",      araddr,        m_araddr);
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("busy",        32'(busy),     32'((m_arq.size() != 0) || (m_out != 0)));
        chk("arcfg",       32'({arlen, arsize, arburst}), 32'({4'd7, 3'd3, 2'b10}));
`ifdef CC_MISS_STAT_EN
        chk("miss_cnt",    miss_cnt,  m_miss);
        chk("stall_cnt",   stall_cnt, m_stall);
`endif
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if ((m_arq.size() != 0) && arready) void'(m_arq.pop_front());
            if (rst_n && miss_req && (m_arq.size() == 0) && !e_acc && !(arready && arvalid))
                m_stall = m_stall + 32'd1;
            if (e_acc) begin
                m_araddr = {miss_addr[31:3], 3'b000};
                m_arq.push_back(m_araddr);
                m_miss = m_miss + 32'd1;
            end
            if (e_acc && dec) begin
                // both events: count unchanged
            end else if (e_acc) begin
                m_out++;
            end else if (dec && m_out > 0) begin
                m_out--;
            end
            m_last_acc = e_acc;
        end
        #1;
    endtask

    task automatic idle_inputs();
        miss_req  = 1'b0;
        miss_addr = 32'd0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rready    = 1'b0;
        rlast     = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic rlast_beats(input int n);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        repeat (n) cycle();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    // Present a miss, let it be accepted, then complete the AR handshake.
    task automatic one_miss(input logic [31:0] addr);
        miss_req = 1'b1; miss_addr = addr;
        cycle();
        miss_req = 1'b0;
        arready  = 1'b1;
        cycle();
        arready  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Single miss, critical-word-first address, then the full 8-beat burst
        miss_req = 1'b1; miss_addr = 32'h0000_1238;
        cycle();
        miss_req = 1'b0;
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_araddr",  araddr, 32'h0000_1238);
        chk("t1_out",     32'(outstanding), 32'd1);
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rlast = (i == 7);
            cycle();
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        cycle();
        chk("t1_busy", 32'(busy), 32'd0);

        // arready held low: AR stays put and a second miss waits
        miss_req = 1'b1; miss_addr = 32'h0000_2004;
        cycle();
        miss_addr = 32'h0000_3008;
        repeat (5) cycle();
        chk("t2_araddr_hold", araddr, 32'h0000_2000);
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        cycle();
        miss_req = 1'b0;
        arready  = 1'b1;
        cycle();
        arready  = 1'b0;
        chk("t2_out", 32'(outstanding), 32'd2);
        rlast_beats(2);

        // FIFO full blocks, release acks in the same cycle
        fifo_full = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_4010;
        repeat (3) cycle();
        fifo_full = 1'b0;
        cycle();
        miss_req = 1'b0;
        arready = 1'b1;
        cycle();
        arready = 1'b0;

        // Fill to the limit, 5th miss waits for one last beat
        for (int i = 0; i < 3; i++) one_miss(32'h0000_5000 + 32'(i * 64));
        chk("t4_full", 32'(outstanding), 32'd4);
        miss_req = 1'b1; miss_addr = 32'h0000_6000;
        repeat (3) cycle();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        cycle();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        cycle();
        miss_req = 1'b0;
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        chk("t4_after", 32'(outstanding), 32'd4);

        // Accept and last beat together, then a spurious last beat at zero
        rlast_beats(2);
        miss_req = 1'b1; miss_addr = 32'h0000_7000;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        cycle();
        miss_req = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        chk("t5_same", 32'(outstanding), 32'd2);
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        rlast_beats(3);
        chk("t5_spurious", 32'(outstanding), 32'd0);

        // Reset while an AR is pending with three bursts in flight
        one_miss(32'h0000_8000);
        one_miss(32'h0000_8040);
        miss_req = 1'b1; miss_addr = 32'h0000_8080;
        cycle();
        miss_req = 1'b0;
        cycle();
        chk("t6_pre", 32'(outstanding), 32'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_arvalid", 32'(arvalid), 32'd0);
        chk("t6_out",     32'(outstanding), 32'd0);
`ifdef CC_MISS_STAT_EN
        chk("t6_miss_cnt", miss_cnt, 32'd0);
`endif
        cycle();

        // Randomized traffic; requester holds address until acked
        for (int n = 0; n < 3000; n++) begin
            if (!(miss_req && !m_last_acc)) begin
                miss_req  = ($urandom_range(0, 2) != 0);
                miss_addr = $urandom;
            end
            arready   = $urandom_range(0, 1);
            rvalid    = ($urandom_range(0, 3) != 0);
            rready    = ($urandom_range(0, 3) != 0);
            rlast     = ($urandom_range(0, 5) == 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
